// File: rtl/acc_ctrl_regs_if.sv
// AXI4-Lite bus bundle between the PS GP master and the accelerator control register block.
interface acc_ctrl_regs_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/acc_ctrl_regs.sv
// AXI4-Lite control/status registers for the convolution accelerator: CTRL, STATUS, CFG, RESULT.
// Turns bus writes into start/soft-reset pulses and captures core completion for readback and irq.
module acc_ctrl_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    acc_ctrl_regs_if.slave    s_axi,
    output logic              acc_start,
    output logic              acc_soft_rst,
    output logic [31:0]       acc_cfg,
    input  logic              acc_busy,
    input  logic              acc_done,
    input  logic [31:0]       acc_result,
    output logic              irq
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  aw_idx, ar_idx;
    logic        wr_en, rd_en;

    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        start_q, start_d;
    logic        soft_rst_q, soft_rst_d;
    logic        irq_en_q, irq_en_d;
    logic [31:0] cfg_q, cfg_d;
    logic        done_q, done_d;
    logic [15:0] done_cnt_q, done_cnt_d;
    logic [31:0] result_q, result_d;
    logic        irq_q, irq_d;

    logic        soft_req, start_req, done_clr;
    logic        unused_ok;

    assign aw_addr = s_axi.S_AXI_AWADDR;
    assign ar_addr = s_axi.S_AXI_ARADDR;
    assign wdata   = s_axi.S_AXI_WDATA;
    assign wstrb   = s_axi.S_AXI_WSTRB;
    assign aw_idx  = aw_addr[3:2];
    assign ar_idx  = ar_addr[3:2];

    // Ready is registered, so a handshake completes on the edge where ready and valid are both high
    assign wr_en = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
    assign rd_en = arready_q & s_axi.S_AXI_ARVALID;

    always_comb begin
        awready_d  = ~awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        start_d    = 1'b0;
        soft_rst_d = 1'b0;
        irq_en_d   = irq_en_q;
        cfg_d      = cfg_q;
        done_d     = done_q;
        done_cnt_d = done_cnt_q;
        result_d   = result_q;
        soft_req   = 1'b0;
        start_req  = 1'b0;
        done_clr   = 1'b0;

        if (wr_en) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (aw_idx)
                2'd0: begin
                    soft_req  = wstrb[3] & wdata[31];
                    start_req = wstrb[0] & wdata[0] & ~soft_req;
                    if (wstrb[0]) irq_en_d = wdata[1];
                    if (start_req) begin
                        if (acc_busy) bresp_d = RESP_SLVERR;
                        else          start_d = 1'b1;
                    end
                    soft_rst_d = soft_req;
                end
                2'd1: done_clr = wstrb[0] & wdata[1];
                2'd2: begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb[b]) cfg_d[8*b +: 8] = wdata[8*b +: 8];
                    end
                end
                default: ;
            endcase
        end else if (s_axi.S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        // Soft reset beats a same-cycle completion, which in turn beats the W1C of DONE
        if (soft_req) begin
            done_d     = 1'b0;
            done_cnt_d = 16'd0;
            result_d   = 32'd0;
        end else if (acc_done) begin
            done_d     = 1'b1;
            done_cnt_d = done_cnt_q + 16'd1;
            result_d   = acc_result;
        end else if (done_clr) begin
            done_d = 1'b0;
        end

        irq_d = done_q & irq_en_q;

        arready_d = ~arready_q & s_axi.S_AXI_ARVALID & ~rvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (rd_en) begin
            rvalid_d = 1'b1;
            case (ar_idx)
                2'd0:    rdata_d = {30'd0, irq_en_q, 1'b0};
                2'd1:    rdata_d = {done_cnt_q, 14'd0, done_q, acc_busy};
                2'd2:    rdata_d = cfg_q;
                default: rdata_d = result_q;
            endcase
        end else if (s_axi.S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'd0;
            start_q    <= 1'b0;
            soft_rst_q <= 1'b0;
            irq_en_q   <= 1'b0;
            cfg_q      <= 32'd0;
            done_q     <= 1'b0;
            done_cnt_q <= 16'd0;
            result_q   <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            start_q    <= start_d;
            soft_rst_q <= soft_rst_d;
            irq_en_q   <= irq_en_d;
            cfg_q      <= cfg_d;
            done_q     <= done_d;
            done_cnt_q <= done_cnt_d;
            result_q   <= result_d;
            irq_q      <= irq_d;
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = awready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;

    assign acc_start    = start_q;
    assign acc_soft_rst = soft_rst_q;
    assign acc_cfg      = cfg_q;
    assign irq          = irq_q;

    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, aw_addr, ar_addr};
endmodule

// File: tb/tb_acc_ctrl_regs.sv
// Self-checking bench for acc_ctrl_regs: directed register-map scenarios plus randomized traffic
// compared against a transaction-level model of the register file.
module tb_acc_ctrl_regs;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        acc_start, acc_soft_rst, acc_busy, acc_done, irq;
    logic [31:0] acc_cfg, acc_result;

    int errors = 0;
    int checks = 0;

    // Reference model of the visible register state
    logic [31:0] mCfg;
    logic        mIrqEn;
    logic        mDone;
    logic [15:0] mCnt;
    logic [31:0] mResult;

    acc_ctrl_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) axi ();

    acc_ctrl_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (axi),
        .acc_start     (acc_start),
        .acc_soft_rst  (acc_soft_rst),
        .acc_cfg       (acc_cfg),
        .acc_busy      (acc_busy),
        .acc_done      (acc_done),
        .acc_result    (acc_result),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] modelRead(input logic [1:0] idx);
        case (idx)
            2'd0:    return {30'd0, mIrqEn, 1'b0};
            2'd1:    return {mCnt, 14'd0, mDone, acc_busy};
            2'd2:    return mCfg;
            default: return mResult;
        endcase
    endfunction

    task automatic modelReset();
        mCfg = 32'd0; mIrqEn = 1'b0; mDone = 1'b0; mCnt = 16'd0; mResult = 32'd0;
    endtask

    // Valids stay asserted until the B handshake so a premature second AWREADY would be seen
    task automatic applyWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input int bDelay, input bit doneAtAccept, input logic [31:0] doneResult);
        logic [1:0] expResp;
        bit expStart, expSoft, clr, irqBefore;
        int waitN;
        expResp = 2'b00; expStart = 0; expSoft = 0; clr = 0;
        axi.S_AXI_AWADDR = addr; axi.S_AXI_WDATA = data; axi.S_AXI_WSTRB = strb;
        axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1; axi.S_AXI_BREADY = 1'b0;
        waitN = 0;
        while (axi.S_AXI_AWREADY !== 1'b1 && waitN < 20) begin
            nextCycle();
            waitN++;
        end
        if (waitN >= 20) begin
            checkOutput("aw_timeout", 32'd0, 32'd1);
            axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
            return;
        end
        checkOutput("wready_with_awready", axi.S_AXI_WREADY, 1);
        irqBefore = mDone & mIrqEn;
        case (addr[3:2])
            2'd0: begin
                expSoft = strb[3] & data[31];
                if (strb[0] && data[0] && !expSoft) begin
                    if (acc_busy) expResp = 2'b10;
                    else          expStart = 1;
                end
            end
            2'd1: clr = strb[0] & data[1];
            default: ;
        endcase
        if (doneAtAccept) begin
            acc_done = 1'b1;
            acc_result = doneResult;
        end
        nextCycle();
        acc_done = 1'b0;
        if (addr[3:2] == 2'd0 && strb[0]) mIrqEn = data[1];
        if (addr[3:2] == 2'd2)
            for (int b = 0; b < 4; b++) if (strb[b]) mCfg[8*b +: 8] = data[8*b +: 8];
        if (expSoft) begin
            mDone = 1'b0; mCnt = 16'd0; mResult = 32'd0;
        end else if (doneAtAccept) begin
            mDone = 1'b1; mCnt = mCnt + 16'd1; mResult = doneResult;
        end else if (clr) begin
            mDone = 1'b0;
        end
        checkOutput("bvalid_after_accept", axi.S_AXI_BVALID, 1);
        checkOutput("bresp", axi.S_AXI_BRESP, expResp);
        checkOutput("awready_after_accept", axi.S_AXI_AWREADY, 0);
        checkOutput("acc_start_pulse", acc_start, expStart);
        checkOutput("acc_soft_rst_pulse", acc_soft_rst, expSoft);
        checkOutput("irq_lag", irq, irqBefore);
        checkOutput("acc_cfg", acc_cfg, mCfg);
        nextCycle();
        checkOutput("acc_start_end", acc_start, 0);
        checkOutput("acc_soft_rst_end", acc_soft_rst, 0);
        checkOutput("irq_settled", irq, mDone & mIrqEn);
        for (int i = 0; i < bDelay; i++) begin
            checkOutput("bvalid_hold", axi.S_AXI_BVALID, 1);
            checkOutput("bresp_hold", axi.S_AXI_BRESP, expResp);
            checkOutput("awready_hold", axi.S_AXI_AWREADY, 0);
            nextCycle();
        end
        axi.S_AXI_BREADY = 1'b1;
        nextCycle();
        axi.S_AXI_BREADY = 1'b0;
        axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
        checkOutput("bvalid_cleared", axi.S_AXI_BVALID, 0);
    endtask

    task automatic applyRead(input logic [3:0] addr, input int rDelay, output logic [31:0] rd);
        logic [31:0] exp;
        int waitN;
        rd = 32'hDEAD_BEEF;
        axi.S_AXI_ARADDR = addr; axi.S_AXI_ARVALID = 1'b1; axi.S_AXI_RREADY = 1'b0;
        waitN = 0;
        while (axi.S_AXI_ARREADY !== 1'b1 && waitN < 20) begin
            nextCycle();
            waitN++;
        end
        if (waitN >= 20) begin
            checkOutput("ar_timeout", 32'd0, 32'd1);
            axi.S_AXI_ARVALID = 1'b0;
            return;
        end
        exp = modelRead(addr[3:2]);
        nextCycle();
        rd = axi.S_AXI_RDATA;
        checkOutput("rvalid_after_accept", axi.S_AXI_RVALID, 1);
        checkOutput("rdata", axi.S_AXI_RDATA, exp);
        checkOutput("rresp", axi.S_AXI_RRESP, 0);
        checkOutput("arready_after_accept", axi.S_AXI_ARREADY, 0);
        for (int i = 0; i < rDelay; i++) begin
            nextCycle();
            checkOutput("rvalid_hold", axi.S_AXI_RVALID, 1);
            checkOutput("rdata_hold", axi.S_AXI_RDATA, exp);
            checkOutput("arready_hold", axi.S_AXI_ARREADY, 0);
        end
        axi.S_AXI_RREADY = 1'b1;
        nextCycle();
        axi.S_AXI_RREADY = 1'b0;
        axi.S_AXI_ARVALID = 1'b0;
        checkOutput("rvalid_cleared", axi.S_AXI_RVALID, 0);
    endtask

    task automatic pulseDone(input logic [31:0] res);
        bit irqBefore;
        irqBefore = mDone & mIrqEn;
        acc_done = 1'b1;
        acc_result = res;
        nextCycle();
        acc_done = 1'b0;
        mDone = 1'b1; mCnt = mCnt + 16'd1; mResult = res;
        checkOutput("irq_lag_done", irq, irqBefore);
        nextCycle();
        checkOutput("irq_after_done", irq, mDone & mIrqEn);
    endtask

    initial begin
        logic [31:0] rd, data;
        logic [3:0]  addr;
        rst_n = 1'b0;
        acc_busy = 1'b0; acc_done = 1'b0; acc_result = 32'd0;
        axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 1'b0;
        axi.S_AXI_BREADY = 1'b0;
        axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY = 1'b0;
        modelReset();
        repeat (3) nextCycle();
        rst_n = 1'b1;
        nextCycle();

        checkOutput("rst_awready", axi.S_AXI_AWREADY, 0);
        checkOutput("rst_wready", axi.S_AXI_WREADY, 0);
        checkOutput("rst_bvalid", axi.S_AXI_BVALID, 0);
        checkOutput("rst_bresp", axi.S_AXI_BRESP, 0);
        checkOutput("rst_arready", axi.S_AXI_ARREADY, 0);
        checkOutput("rst_rvalid", axi.S_AXI_RVALID, 0);
        checkOutput("rst_rresp", axi.S_AXI_RRESP, 0);
        checkOutput("rst_acc_start", acc_start, 0);
        checkOutput("rst_acc_soft_rst", acc_soft_rst, 0);
        checkOutput("rst_acc_cfg", acc_cfg, 0);
        checkOutput("rst_irq", irq, 0);

        // CFG byte strobes
        applyWrite(4'h8, 32'h0000_00AB, 4'hF, 0, 0, 0);
        applyWrite(4'h8, 32'hFFFF_FFFF, 4'h2, 0, 0, 0);
        applyRead(4'h8, 0, rd);
        checkOutput("cfg_strobe_read", rd, 32'h0000_FFAB);
        checkOutput("cfg_strobe_port", acc_cfg, 32'h0000_FFAB);

        // START idle and busy
        applyWrite(4'h0, 32'h1, 4'hF, 0, 0, 0);
        applyRead(4'h0, 0, rd);
        checkOutput("ctrl_reads_zero", rd, 32'h0);
        acc_busy = 1'b1;
        applyWrite(4'h0, 32'h1, 4'hF, 0, 0, 0);
        acc_busy = 1'b0;

        // Completion, irq, W1C
        applyWrite(4'h0, 32'h2, 4'hF, 0, 0, 0);
        pulseDone(32'h1234_5678);
        applyRead(4'h4, 0, rd);
        checkOutput("status_after_done", rd, 32'h0001_0002);
        applyRead(4'hC, 0, rd);
        checkOutput("result_after_done", rd, 32'h1234_5678);
        checkOutput("irq_asserted", irq, 1);
        applyWrite(4'h4, 32'h2, 4'hF, 0, 0, 0);
        applyRead(4'h4, 0, rd);
        checkOutput("status_after_w1c", rd, 32'h0001_0000);
        checkOutput("irq_dropped", irq, 0);

        // Set beats W1C, then soft reset clears
        applyWrite(4'h4, 32'h2, 4'hF, 0, 1, 32'hCAFE_F00D);
        applyRead(4'h4, 0, rd);
        checkOutput("status_set_wins", rd, 32'h0002_0002);
        applyWrite(4'h0, 32'h8000_0000, 4'hF, 0, 0, 0);
        applyRead(4'h4, 0, rd);
        checkOutput("status_after_soft", rd, 32'h0);
        applyRead(4'hC, 0, rd);
        checkOutput("result_after_soft", rd, 32'h0);

        // Soft reset with START and a coincident completion: clear wins, no start, OKAY
        pulseDone(32'h0BAD_0001);
        applyWrite(4'h0, 32'h8000_0001, 4'hF, 0, 1, 32'h5555_AAAA);
        applyRead(4'h4, 0, rd);
        checkOutput("status_soft_beats_done", rd, 32'h0);

        // Back-pressure on both response channels
        applyWrite(4'h8, 32'h1357_9BDF, 4'hF, 5, 0, 0);
        applyRead(4'h8, 5, rd);
        checkOutput("cfg_after_hold", rd, 32'h1357_9BDF);

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    addr = {2'($urandom_range(0, 3)), 2'b00};
                    data = $urandom;
                    if ($urandom_range(0, 7) != 0) data[31] = 1'b0;
                    applyWrite(addr, data, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                               ($urandom_range(0, 3) == 0), $urandom);
                end
                1: begin
                    addr = {2'($urandom_range(0, 3)), 2'b00};
                    applyRead(addr, $urandom_range(0, 2), rd);
                end
                2: pulseDone($urandom);
                default: begin
                    acc_busy = 1'($urandom_range(0, 1));
                    nextCycle();
                    checkOutput("irq_idle", irq, mDone & mIrqEn);
                end
            endcase
        end
        acc_busy = 1'b0;

        // Read and write in flight together
        fork
            applyWrite(4'h8, 32'h5A5A_1234, 4'hF, 1, 0, 0);
            begin
                logic [31:0] rdc;
                applyRead(4'hC, 2, rdc);
            end
        join
        checkOutput("cfg_after_concurrent", acc_cfg, mCfg);

        // Asynchronous reset with responses outstanding
        axi.S_AXI_AWADDR = 4'h8; axi.S_AXI_WDATA = 32'hFFFF_0000; axi.S_AXI_WSTRB = 4'hF;
        axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1; axi.S_AXI_BREADY = 1'b0;
        axi.S_AXI_ARADDR = 4'h0; axi.S_AXI_ARVALID = 1'b1; axi.S_AXI_RREADY = 1'b0;
        nextCycle();
        nextCycle();
        checkOutput("pre_rst_bvalid", axi.S_AXI_BVALID, 1);
        checkOutput("pre_rst_rvalid", axi.S_AXI_RVALID, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_awready", axi.S_AXI_AWREADY, 0);
        checkOutput("mid_rst_wready", axi.S_AXI_WREADY, 0);
        checkOutput("mid_rst_bvalid", axi.S_AXI_BVALID, 0);
        checkOutput("mid_rst_arready", axi.S_AXI_ARREADY, 0);
        checkOutput("mid_rst_rvalid", axi.S_AXI_RVALID, 0);
        checkOutput("mid_rst_cfg", acc_cfg, 0);
        axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0; axi.S_AXI_ARVALID = 1'b0;
        modelReset();
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
        checkOutput("post_rst_bvalid", axi.S_AXI_BVALID, 0);
        applyRead(4'h4, 0, rd);
        checkOutput("post_rst_status", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
